// File: rtl/network_interface.sv
// Mesh network interface: credit-based flit injection toward the local router port and a
// first-word-fall-through ejection FIFO toward the core, with sticky overflow flags.
module network_interface #(
    parameter logic [7:0] MY_ADDR   = 8'h00,
    parameter int         CREDITS   = 4,
    parameter int         RXQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_dest_i,
    input  logic [23:0] tx_data_i,
    output logic        tx_ready_o,
    output logic [31:0] inj_flit_o,
    output logic        inj_valid_o,
    input  logic        credit_i,
    input  logic [31:0] ej_flit_i,
    input  logic        ej_valid_i,
    output logic        l_incr_o,
    output logic        rx_valid_o,
    output logic [23:0] rx_data_o,
    input  logic        rx_ready_i,
    output logic [1:0]  err_o
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int AW = $clog2(RXQ_DEPTH);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [AW:0]   RXQ_FULL = (AW + 1)'(RXQ_DEPTH);

    // Self-addressed flits take the normal injection path; the ejected header is already
    // routed here, so neither the node address nor the header byte steers any logic.
    logic unused_hdr;
    assign unused_hdr = ^{ej_flit_i[31:24], MY_ADDR};

    function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cnt,
                                                  input logic          take,
                                                  input logic          give);
        logic [CW-1:0] res;
        res = cnt;
        if (take && !give) begin
            res = cnt - CW'(1);
        end else if (give && !take && (cnt != CRED_MAX)) begin
            res = cnt + CW'(1);
        end
        return res;
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return ptr + AW'(1);
    endfunction

    logic [CW-1:0] cred_q, cred_d;
    logic          inj_valid_q, inj_valid_d;
    logic [31:0]   inj_flit_q, inj_flit_d;
    logic          l_incr_q, l_incr_d;
    logic [1:0]    err_q, err_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   rx_cnt_q, rx_cnt_d;
    logic [23:0]   rxq_mem_q [RXQ_DEPTH];

    logic accept, pop, push, drop, cred_ovf, rx_empty, rx_full;

    assign tx_ready_o = rst && (cred_q != '0);
    assign accept     = tx_valid_i && tx_ready_o;
    assign cred_ovf   = rst && credit_i && !accept && (cred_q == CRED_MAX);

    assign rx_empty   = (rx_cnt_q == '0);
    assign rx_full    = (rx_cnt_q == RXQ_FULL);
    assign pop        = rst && !rx_empty && rx_ready_i;
    // A full FIFO still takes the new flit when the head leaves in the same cycle.
    assign push       = rst && ej_valid_i && (!rx_full || pop);
    assign drop       = rst && ej_valid_i && rx_full && !pop;

    always_comb begin
        cred_d      = credit_next(cred_q, accept, credit_i);
        inj_valid_d = accept;
        inj_flit_d  = inj_flit_q;
        l_incr_d    = pop;
        err_d       = err_q | {cred_ovf, drop};
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        if (accept) begin
            inj_flit_d = {tx_dest_i, tx_data_i};
        end
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            rx_cnt_d = rx_cnt_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            rx_cnt_d = rx_cnt_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cred_q      <= CRED_MAX;
            inj_valid_q <= 1'b0;
            inj_flit_q  <= '0;
            l_incr_q    <= 1'b0;
            err_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rx_cnt_q    <= '0;
        end else begin
            cred_q      <= cred_d;
            inj_valid_q <= inj_valid_d;
            inj_flit_q  <= inj_flit_d;
            l_incr_q    <= l_incr_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            rxq_mem_q[wr_ptr_q] <= ej_flit_i[23:0];
        end
    end

    assign inj_valid_o = inj_valid_q;
    assign inj_flit_o  = inj_flit_q;
    assign l_incr_o    = l_incr_q;
    assign err_o       = err_q;
    assign rx_valid_o  = !rx_empty;
    assign rx_data_o   = rx_empty ? '0 : rxq_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_network_interface.sv
// Bench for network_interface: reference model with scoreboards for injected flits and
// ejected payloads, directed scenarios followed by a random phase.
module tb_network_interface;

    localparam int CREDITS   = 4;
    localparam int RXQ_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx_valid_i = 1'b0;
    logic [7:0]  tx_dest_i = '0;
    logic [23:0] tx_data_i = '0;
    logic        tx_ready_o;
    logic [31:0] inj_flit_o;
    logic        inj_valid_o;
    logic        credit_i = 1'b0;
    logic [31:0] ej_flit_i = '0;
    logic        ej_valid_i = 1'b0;
    logic        l_incr_o;
    logic        rx_valid_o;
    logic [23:0] rx_data_o;
    logic        rx_ready_i = 1'b0;
    logic [1:0]  err_o;

    network_interface #(.MY_ADDR(8'h00), .CREDITS(CREDITS), .RXQ_DEPTH(RXQ_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .tx_valid_i(tx_valid_i), .tx_dest_i(tx_dest_i), .tx_data_i(tx_data_i),
        .tx_ready_o(tx_ready_o), .inj_flit_o(inj_flit_o), .inj_valid_o(inj_valid_o),
        .credit_i(credit_i), .ej_flit_i(ej_flit_i), .ej_valid_i(ej_valid_i),
        .l_incr_o(l_incr_o), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
        .rx_ready_i(rx_ready_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int inj_pulses = 0;

    logic [31:0] inj_q[$];
    logic [23:0] rx_q[$];
    int          m_cred = CREDITS;
    logic [1:0]  m_err = 2'b00;
    logic [31:0] m_inj_last = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: compare combinational outputs, advance the model, then compare
    // registered outputs just after the edge.
    task automatic cycle();
        logic acc, pop;
        logic [31:0] f;
        #1;
        check("tx_ready", 32'(tx_ready_o), 32'(rst && m_cred != 0));
        check("rx_valid", 32'(rx_valid_o), 32'(rx_q.size() != 0));
        if (rx_q.size() != 0) check("rx_data", 32'(rx_data_o), 32'(rx_q[0]));
        else                  check("rx_data_empty", 32'(rx_data_o), 32'h0);
        acc = rst && tx_valid_i && (m_cred != 0);
        pop = rst && rx_ready_i && (rx_q.size() != 0);
        if (!rst) begin
            m_cred = CREDITS;
            m_err = 2'b00;
            m_inj_last = '0;
            rx_q.delete();
            inj_q.delete();
        end else begin
            if (acc) inj_q.push_back({tx_dest_i, tx_data_i});
            if (acc && !credit_i) m_cred--;
            else if (credit_i && !acc) begin
                if (m_cred == CREDITS) m_err[1] = 1'b1;
                else m_cred++;
            end
            if (pop) void'(rx_q.pop_front());
            if (ej_valid_i) begin
                if (rx_q.size() < RXQ_DEPTH) rx_q.push_back(ej_flit_i[23:0]);
                else m_err[0] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("inj_valid", 32'(inj_valid_o), 32'(acc));
        if (inj_valid_o === 1'b1) begin
            inj_pulses++;
            if (inj_q.size() == 0) check("inj_unexpected", inj_flit_o, 32'hxxxxxxxx);
            else begin
                f = inj_q.pop_front();
                check("inj_flit", inj_flit_o, f);
                m_inj_last = f;
            end
        end else begin
            check("inj_hold", inj_flit_o, m_inj_last);
        end
        check("l_incr", 32'(l_incr_o), 32'(pop));
        check("err", 32'(err_o), 32'(m_err));
    endtask

    task automatic idle_inputs();
        tx_valid_i = 1'b0;
        credit_i   = 1'b0;
        ej_valid_i = 1'b0;
        rx_ready_i = 1'b0;
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        rst = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with a flit offered while reset is held.
        tx_valid_i = 1'b1;
        tx_dest_i = 8'h11;
        tx_data_i = 24'h123456;
        rst = 1'b0;
        cycle();
        cycle();
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_inj_flit", inj_flit_o, 32'h0);
        rst = 1'b1;

        // Accept on the first edge after reset, five back-to-back offers, one self-addressed.
        inj_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tx_valid_i = 1'b1;
            tx_dest_i = (i == 0) ? 8'h21 : ((i == 2) ? 8'h00 : 8'(8'h30 + i));
            tx_data_i = (i == 0) ? 24'hABCDEF : 24'(24'h100 * (i + 1));
            if (i == 4) check("tx_ready_5th", 32'(tx_ready_o), 32'h0);
            cycle();
            if (i == 0) check("inj_21ABCDEF", inj_flit_o, 32'h21ABCDEF);
        end
        idle_inputs();
        cycle();
        check("inj_pulses4", 32'(inj_pulses), 32'd4);

        // Credit return at zero, then accept and credit in the same cycle.
        credit_i = 1'b1;
        cycle();
        credit_i = 1'b0;
        check("ready_after_credit", 32'(tx_ready_o), 32'h1);
        tx_valid_i = 1'b1;
        tx_dest_i = 8'h42;
        tx_data_i = 24'h00BEEF;
        credit_i = 1'b1;
        cycle();
        credit_i = 1'b0;
        check("ready_after_both", 32'(tx_ready_o), 32'h1);
        tx_data_i = 24'h00CAFE;
        cycle();
        tx_valid_i = 1'b0;
        cycle();
        check("ready_zero_again", 32'(tx_ready_o), 32'h0);

        // Ejection overflow and in-order drain with credit returns.
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            ej_valid_i = 1'b1;
            ej_flit_i = {8'h00, 24'(24'hE00000 + i)};
            cycle();
        end
        ej_valid_i = 1'b0;
        check("err_rx_ovf", 32'(err_o), 32'h1);
        rx_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        rx_ready_i = 1'b0;
        check("rx_drained", 32'(rx_valid_o), 32'h0);

        // Full FIFO with eject and pop together.
        for (int i = 0; i < 4; i++) begin
            ej_valid_i = 1'b1;
            ej_flit_i = {8'h00, 24'(24'hF00000 + i)};
            cycle();
        end
        ej_flit_i = {8'h00, 24'hF0F0F0};
        rx_ready_i = 1'b1;
        cycle();
        ej_valid_i = 1'b0;
        check("err_unchanged", 32'(err_o), 32'h1);
        for (int i = 0; i < 5; i++) cycle();
        rx_ready_i = 1'b0;

        // Spurious credit at full count.
        credit_i = 1'b1;
        cycle();
        credit_i = 1'b0;
        check("err_cred_ovf", 32'(err_o), 32'h3);

        // Reset mid-operation with two RX entries and one credit left.
        for (int i = 0; i < 3; i++) begin
            tx_valid_i = 1'b1;
            tx_dest_i = 8'h55;
            tx_data_i = 24'(24'h777000 + i);
            ej_valid_i = (i < 2);
            ej_flit_i = {8'h00, 24'(24'hD00000 + i)};
            rx_ready_i = 1'b0;
            cycle();
        end
        idle_inputs();
        rx_ready_i = 1'b1;
        rst = 1'b0;
        cycle();
        check("midrst_rx_valid", 32'(rx_valid_o), 32'h0);
        check("midrst_err", 32'(err_o), 32'h0);
        rst = 1'b1;
        rx_ready_i = 1'b0;
        inj_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tx_valid_i = 1'b1;
            tx_data_i = 24'(24'h900000 + i);
            cycle();
        end
        tx_valid_i = 1'b0;
        cycle();
        check("midrst_credits4", 32'(inj_pulses), 32'd4);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            tx_valid_i = 1'($urandom_range(0, 1));
            tx_dest_i = 8'($urandom);
            tx_data_i = 24'($urandom);
            credit_i = ($urandom_range(0, 3) == 0);
            ej_valid_i = 1'($urandom_range(0, 1));
            ej_flit_i = $urandom;
            rx_ready_i = 1'($urandom_range(0, 1));
            cycle();
        end
        idle_inputs();
        cycle();
        check("inj_sb_empty", 32'(inj_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/network_interface.md
NETWORK_INTERFACE -- requirements
Module: network_interface

Interface
REQ-001 SHALL have parameter MY_ADDR, default 8'h00, meaning this node's {x[3:0],y[3:0]} mesh address.
REQ-002 SHALL have parameter CREDITS, default 4, meaning the depth of the router local input buffer and the initial credit count.
REQ-003 SHALL have parameter RXQ_DEPTH, default 4, meaning ejection FIFO entries (power of two).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-low reset.
REQ-006 SHALL have port tx_valid_i, input, 1, meaning core offers a flit.
REQ-007 SHALL have port tx_dest_i, input, 8, meaning destination {x,y}.
REQ-008 SHALL have port tx_data_i, input, 24, meaning payload.
REQ-009 SHALL have port tx_ready_o, output, 1, meaning NI accepts the flit this cycle.
REQ-010 SHALL have port inj_flit_o, output, 32, meaning flit to the router local input, format {dest[7:0],payload[23:0]}.
REQ-011 SHALL have port inj_valid_o, output, 1, meaning inj_flit_o is valid, one-cycle pulse per flit.
REQ-012 SHALL have port credit_i, input, 1, meaning router freed one local-input slot.
REQ-013 SHALL have port ej_flit_i, input, 32, meaning flit from the router local output.
REQ-014 SHALL have port ej_valid_i, input, 1, meaning ej_flit_i is valid.
REQ-015 SHALL have port l_incr_o, output, 1, meaning credit return to the router, one pulse per popped RX entry.
REQ-016 SHALL have port rx_valid_o / rx_data_o / rx_ready_i, output 1 / output 24 / input 1, meaning core ejection handshake.
REQ-017 SHALL have port err_o, output, 2, meaning sticky {credit_overflow, rx_overflow}.

Function
REQ-018 SHALL keep a credit counter, width clog2(CREDITS+1), reset to CREDITS.
REQ-019 SHALL drive tx_ready_o = rst && (credit counter != 0), combinationally.
REQ-020 SHALL register the flit on tx_valid_i && tx_ready_o: next cycle inj_valid_o=1 and inj_flit_o={tx_dest_i,tx_data_i}; latency 1.
REQ-021 SHALL hold inj_flit_o at its last value when inj_valid_o=0.
REQ-022 SHALL update credits per cycle: accept-only -1, credit_i-only +1, both or neither unchanged.
REQ-023 SHALL ignore credit_i when the counter already equals CREDITS and no accept occurs, and SHALL set err_o[1].
REQ-024 SHALL inject self-addressed flits (dest==MY_ADDR) normally, without any loopback.
REQ-025 SHALL write ej_flit_i[23:0] into the RX FIFO on ej_valid_i when not full, or when full with a pop in the same cycle.
REQ-026 SHALL drop ej_valid_i on a full FIFO with no pop, and SHALL set err_o[0].
REQ-027 SHALL make the RX FIFO first-word-fall-through: rx_valid_o = !empty, rx_data_o = head entry.
REQ-028 SHALL pop on rx_valid_o && rx_ready_i, and SHALL pulse l_incr_o the following cycle (registered, latency 1).
REQ-029 SHALL support simultaneous push and pop with occupancy unchanged, and SHALL wrap pointers modulo RXQ_DEPTH.
REQ-030 SHALL clear err_o bits only on reset.

Reset
REQ-031 SHALL, while rst=0 at a clock edge: credits=CREDITS, FIFO empty, inj_valid_o=0, inj_flit_o=0, l_incr_o=0, rx_valid_o=0, rx_data_o=0, err_o=0.
REQ-032 SHALL keep tx_ready_o=0 while rst=0, and SHALL discard in-flight FIFO contents and pending l_incr_o on reset mid-operation.
REQ-033 SHALL accept a flit on the first edge after rst rises.

Verification
REQ-034 SHALL cover: 5 back-to-back tx_valid_i with no credit_i, CREDITS=4 -> 4 accepted, inj_valid_o pulses 4 times, tx_ready_o=0 at the 5th.
REQ-035 SHALL cover: credits=0 with credit_i pulse -> tx_ready_o=1 next cycle; accept+credit_i same cycle -> count unchanged.
REQ-036 SHALL cover: tx dest=8'h21, data=24'hABCDEF -> inj_flit_o=32'h21ABCDEF one cycle later.
REQ-037 SHALL cover: 4 ejects with rx_ready_i=0, then a 5th -> 5th dropped, err_o=2'b01; then rx_ready_i=1 -> 4 pops in order, 4 l_incr_o pulses each lagging its pop by 1.
REQ-038 SHALL cover: FIFO full, eject+pop same cycle -> both succeed, err_o unchanged.
REQ-039 SHALL cover: rst=0 asserted with 2 RX entries and credits=1 -> next cycle rx_valid_o=0, credits=4, err_o=0.
